pixel_write_arbiter: RTL and testbench
======================================

// Module: pixel_write_arbiter
// PURPOSE
//  Sole owner of the pixel store write port (wx, wy, newColor, write strobe).
//  Shares it between two requesters:
//   - SPI brush-stroke writes from the SPI decode path, buffered in a small FIFO.
//   - An internal clear-screen engine that sweeps every canvas pixel to one colour.
//  Issues at most one write per clk, only while wr_allow=1.
// PARAMETERS
//  CANVAS_W    160  canvas width in pixels; x range 0..CANVAS_W-1
//  CANVAS_H    120  canvas height in pixels; y range 0..CANVAS_H-1
//  FIFO_DEPTH  4    brush request buffer entries; power of 2, >=2
// PORTS
//  clk          in   1  pixel clock (25.175 MHz PLL output)
//  reset        in   1  synchronous, active-high
//  req_valid    in   1  brush write request valid
//  req_x        in   8  brush x
//  req_y        in   8  brush y
//  req_color    in   3  brush colour code
//  req_ready    out  1  request accepted when req_valid & req_ready
//  clear_start  in   1  single-cycle pulse: start a clear-screen sweep
//  clear_color  in   3  fill colour, sampled on the accepted clear_start
//  clear_busy   out  1  clear sweep in progress
//  wr_allow     in   1  write-port enable from pixel store / timing; 0 stalls all writes
//  wr_en        out  1  write strobe to pixel store
//  wr_x         out  8  write x
//  wr_y         out  8  write y
//  wr_color     out  3  write colour code
//  dropped      out  1  1-cycle pulse: accepted request was out of range and discarded
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE. wr_en, wr_x, wr_y, wr_color, clear_busy, dropped = 0.
//   req_ready=0 while reset=1.
//  All outputs except req_ready are registered. req_ready = !fifo_full & !clear_start (combinational).
//  Range check at accept: x>=CANVAS_W or y>=CANVAS_H -> not enqueued; dropped=1 next cycle.
//  FSM states:
//   IDLE:  if clear_start -> CLEAR. Else if FIFO non-empty and wr_allow -> pop head;
//          wr_en=1 with head fields next cycle.
//          Latency: accept at cycle N into empty FIFO with wr_allow=1 -> wr_en at N+1.
//   CLEAR: counters cx,cy start at 0, colour = latched clear_color.
//          Each cycle with wr_allow=1: wr_en=1 at (cx,cy) next cycle, then advance.
//          cx increments first; at CANVAS_W-1 it wraps to 0 and cy increments.
//          After writing (CANVAS_W-1, CANVAS_H-1) -> IDLE.
//          Exactly CANVAS_W*CANVAS_H writes, in raster order.
//          clear_busy=1 from cycle after clear_start through the cycle of the last wr_en.
//          Brush requests are still accepted into the FIFO while space remains;
//          they are written after the sweep completes.
//  Priority: clear_start pre-empts a brush pop in the same cycle.
//   On clear_start: FIFO is flushed (entries accepted before that cycle are discarded).
//   req_ready=0 in that cycle, so no request is accepted then.
//  clear_start while already in CLEAR: ignored (no restart, colour unchanged).
//  wr_allow=0: wr_en=0 next cycle; FIFO and counters hold; no write lost or duplicated.
//  FIFO full: req_ready=0; no overwrite. Simultaneous push+pop when full is not allowed
//   (ready is low); when non-full, push and pop in the same cycle are both performed.
//  Reset mid-sweep or with FIFO occupied: everything returns to reset state next cycle.
// STRUCTURE
//  Package paint_pkg:
//   - color_t (logic [2:0])
//   - coord_t (logic [7:0])
//   - arb_state_t enum {IDLE, CLEAR}
//   - pix_req_t struct {coord_t x; coord_t y; color_t color;}
//  Sub-module pixel_fifo: sync FIFO of pix_req_t, depth FIFO_DEPTH.
//   Ports: push, pop, flush, full, empty, head.
//  Arbiter FSM, sweep counters and output registers live in this module.
// TESTING
//  1. Reset release, FIFO empty, wr_allow=1; push (10,20,c=5) at cycle N
//     -> wr_en=1, wr_x=10, wr_y=20, wr_color=5 at N+1 only.
//  2. wr_allow=0; push 4 requests -> 4th accepted, then req_ready=0.
//     Set wr_allow=1 -> 4 writes in push order on consecutive cycles.
//  3. clear_start with clear_color=3, CANVAS_W=4, CANVAS_H=2 (bench override)
//     -> 8 writes (0,0),(1,0)..(3,1), colour 3; clear_busy falls after the last one.
//  4. 2 entries queued, then clear_start -> entries never written.
//     Push (1,1,c=2) during sweep -> written right after (3,1).
//  5. Push (200,5) with CANVAS_W=160 -> no wr_en; dropped=1 one cycle.
//  6. Assert reset mid-sweep, toggle wr_allow randomly across a sweep
//     -> all outputs 0 after reset.
//     Write count = CANVAS_W*CANVAS_H, no duplicate coordinates.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared types for the pixel write path: coordinates, colour codes,
// arbiter state and the brush request record.
package paint_pkg;

  typedef logic [2:0] color_t;
  typedef logic [7:0] coord_t;

  typedef enum logic {IDLE, CLEAR} arb_state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t color;
  } pix_req_t;

  localparam int CANVAS_W_DEF   = 160;
  localparam int CANVAS_H_DEF   = 120;
  localparam int FIFO_DEPTH_DEF = 4;

  // True when (x,y) lies on a w x h canvas.
  function automatic logic in_canvas(coord_t x, coord_t y, int w, int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Brush request, clear control and pixel-store write port bundle.
interface pixel_write_arbiter_if;
  import paint_pkg::*;

  logic   req_valid;
  coord_t req_x;
  coord_t req_y;
  color_t req_color;
  logic   req_ready;
  logic   clear_start;
  color_t clear_color;
  logic   clear_busy;
  logic   wr_allow;
  logic   wr_en;
  coord_t wr_x;
  coord_t wr_y;
  color_t wr_color;
  logic   dropped;

  modport master (
    output req_valid, req_x, req_y, req_color, clear_start, clear_color, wr_allow,
    input  req_ready, clear_busy, wr_en, wr_x, wr_y, wr_color, dropped
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_start, clear_color, wr_allow,
    output req_ready, clear_busy, wr_en, wr_x, wr_y, wr_color, dropped
  );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of brush requests. Pointers carry one extra
// wrap bit so full/empty need no separate counter. Flush empties it.
module pixel_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  pix_req_t din,
  output logic     full,
  output logic     empty,
  output pix_req_t head
);

  localparam int AW = $clog2(DEPTH);

  pix_req_t      mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Owns the pixel store write port and shares it between buffered brush
// writes and a raster clear-screen sweep. One write per clk at most,
// only while wr_allow is high.
module pixel_write_arbiter
  import paint_pkg::*;
#(
  parameter int CANVAS_W   = CANVAS_W_DEF,
  parameter int CANVAS_H   = CANVAS_H_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_write_arbiter_if.slave  bus
);

  arb_state_t state, state_nxt;
  coord_t     cx, cy;
  color_t     fill;
  pix_req_t   head, req_in, wr_req;
  logic       full, empty, flush;
  logic       accept, in_rng, push_ok;
  logic       issue_brush, clr_go, bypass, fifo_push, fifo_pop;
  logic       x_last, last_px;

  assign req_in        = '{x: bus.req_x, y: bus.req_y, color: bus.req_color};
  assign bus.req_ready = !reset && !full && !bus.clear_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_rng        = in_canvas(bus.req_x, bus.req_y, CANVAS_W, CANVAS_H);
  assign push_ok       = accept && in_rng;
  assign x_last        = (cx == coord_t'(CANVAS_W - 1));
  assign last_px       = x_last && (cy == coord_t'(CANVAS_H - 1));

  // An empty FIFO is bypassed so a fresh request is written on the next clk.
  assign bypass    = issue_brush && empty;
  assign fifo_push = push_ok && !bypass;
  assign fifo_pop  = issue_brush && !empty;
  assign wr_req    = empty ? req_in : head;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (req_in),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Next state and write selection; clear_start pre-empts a brush pop.
  always_comb begin
    state_nxt   = state;
    flush       = 1'b0;
    issue_brush = 1'b0;
    clr_go      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_start) begin
          state_nxt = CLEAR;
          flush     = 1'b1;
        end else if (bus.wr_allow && (!empty || push_ok)) begin
          issue_brush = 1'b1;
        end
      end
      CLEAR: begin
        if (bus.wr_allow) begin
          clr_go = 1'b1;
          if (last_px) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, sweep counters and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cx             <= '0;
      cy             <= '0;
      fill           <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_x       <= '0;
      bus.wr_y       <= '0;
      bus.wr_color   <= '0;
      bus.clear_busy <= 1'b0;
      bus.dropped    <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.wr_en      <= issue_brush || clr_go;
      bus.dropped    <= accept && !in_rng;
      bus.clear_busy <= (state == CLEAR) || (state_nxt == CLEAR);
      if (issue_brush) begin
        bus.wr_x     <= wr_req.x;
        bus.wr_y     <= wr_req.y;
        bus.wr_color <= wr_req.color;
      end else if (clr_go) begin
        bus.wr_x     <= cx;
        bus.wr_y     <= cy;
        bus.wr_color <= fill;
      end
      if (state == IDLE && bus.clear_start) begin
        cx   <= '0;
        cy   <= '0;
        fill <= bus.clear_color;
      end else if (clr_go) begin
        if (x_last) begin
          cx <= '0;
          cy <= cy + 8'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: a 4x2 canvas instance for sweep and FIFO
// scenarios, a default 160x120 instance for range and latency scenarios.
module tb_pixel_write_arbiter;
  import paint_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_write_arbiter_if ia ();
  pixel_write_arbiter_if ib ();

  pixel_write_arbiter #(.CANVAS_W(W), .CANVAS_H(H), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .bus(ia));
  pixel_write_arbiter u_dut_full (
    .clk(clk), .reset(reset), .bus(ib));

  int checks = 0;
  int errors = 0;
  pix_req_t obs_q[$];
  int drop_cnt = 0;

  // Record every write and drop pulse of the small-canvas instance.
  always @(negedge clk) begin
    if (ia.wr_en === 1'b1) obs_q.push_back(pix_req_t'{x: ia.wr_x, y: ia.wr_y, color: ia.wr_color});
    if (ia.dropped === 1'b1) drop_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input int x, input int y, input int c);
    ia.req_valid = v; ia.req_x = coord_t'(x); ia.req_y = coord_t'(y); ia.req_color = color_t'(c);
  endtask

  task automatic drive_b(input bit v, input int x, input int y, input int c);
    ib.req_valid = v; ib.req_x = coord_t'(x); ib.req_y = coord_t'(y); ib.req_color = color_t'(c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1, 1, 1, 1); drive_b(1, 1, 1, 1);
    ia.clear_start = 1'b0; ia.clear_color = '0; ia.wr_allow = 1'b1;
    ib.clear_start = 1'b0; ib.clear_color = '0; ib.wr_allow = 1'b1;
    tick(); tick();
    checks++;
    if (ia.req_ready !== 1'b0 || ib.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req_ready: got %b/%b want 0/0", ia.req_ready, ib.req_ready);
    end
    checks++;
    if ({ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ia.clear_busy, ia.dropped} !== '0) begin
      errors++; $display("FAIL reset_outputs_a: got en=%b x=%0d y=%0d c=%0d busy=%b drop=%b want all 0",
        ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ia.clear_busy, ia.dropped);
    end
    checks++;
    if ({ib.wr_en, ib.wr_x, ib.wr_y, ib.wr_color, ib.clear_busy, ib.dropped} !== '0) begin
      errors++; $display("FAIL reset_outputs_b: got en=%b x=%0d y=%0d c=%0d busy=%b drop=%b want all 0",
        ib.wr_en, ib.wr_x, ib.wr_y, ib.wr_color, ib.clear_busy, ib.dropped);
    end
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  // Accept into an empty FIFO shows up as a single write on the next clk.
  task automatic test_single_write();
    drive_b(1, 10, 20, 5);
    #1;
    checks++;
    if (ib.req_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b want 1", ib.req_ready);
    end
    tick();
    drive_b(0, 0, 0, 0);
    checks++;
    if (ib.wr_en !== 1'b1 || ib.wr_x !== 8'd10 || ib.wr_y !== 8'd20 || ib.wr_color !== 3'd5) begin
      errors++; $display("FAIL single_write: got en=%b (%0d,%0d,c%0d) want en=1 (10,20,c5)",
        ib.wr_en, ib.wr_x, ib.wr_y, ib.wr_color);
    end
    tick();
    checks++;
    if (ib.wr_en !== 1'b0) begin
      errors++; $display("FAIL single_once: got wr_en=%b want 0", ib.wr_en);
    end
  endtask

  // Fill the FIFO while stalled, then drain it back-to-back in push order.
  task automatic test_back_to_back();
    int px[4] = '{0, 3, 2, 1};
    int py[4] = '{0, 1, 0, 1};
    int pc[4] = '{1, 2, 7, 4};
    ia.wr_allow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1, px[i], py[i], pc[i]);
      #1;
      checks++;
      if (ia.req_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, ia.req_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (ia.req_ready !== 1'b0 || ia.wr_en !== 1'b0) begin
      errors++; $display("FAIL full_stall: got ready=%b wr_en=%b want 0/0", ia.req_ready, ia.wr_en);
    end
    drive_a(0, 0, 0, 0);
    ia.wr_allow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ia.wr_en !== 1'b1 || ia.wr_x !== coord_t'(px[i]) || ia.wr_y !== coord_t'(py[i])
          || ia.wr_color !== color_t'(pc[i])) begin
        errors++; $display("FAIL drain[%0d]: got en=%b (%0d,%0d,c%0d) want en=1 (%0d,%0d,c%0d)",
          i, ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, px[i], py[i], pc[i]);
      end
    end
    tick();
    checks++;
    if (ia.wr_en !== 1'b0) begin
      errors++; $display("FAIL drain_end: got wr_en=%b want 0", ia.wr_en);
    end
  endtask

  // Full raster sweep with a steady write enable.
  task automatic test_clear();
    ia.clear_start = 1'b1; ia.clear_color = 3'd3; ia.wr_allow = 1'b1;
    #1;
    checks++;
    if (ia.req_ready !== 1'b0) begin
      errors++; $display("FAIL clear_start_ready: got %b want 0", ia.req_ready);
    end
    tick();
    ia.clear_start = 1'b0;
    checks++;
    if (ia.clear_busy !== 1'b1 || ia.wr_en !== 1'b0) begin
      errors++; $display("FAIL clear_begin: got busy=%b en=%b want 1/0", ia.clear_busy, ia.wr_en);
    end
    for (int i = 0; i < W * H; i++) begin
      tick();
      checks++;
      if (ia.wr_en !== 1'b1 || ia.wr_x !== coord_t'(i % W) || ia.wr_y !== coord_t'(i / W)
          || ia.wr_color !== 3'd3 || ia.clear_busy !== 1'b1) begin
        errors++; $display("FAIL clear_px[%0d]: got en=%b (%0d,%0d,c%0d) busy=%b want en=1 (%0d,%0d,c3) busy=1",
          i, ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ia.clear_busy, i % W, i / W);
      end
    end
    tick();
    checks++;
    if (ia.wr_en !== 1'b0 || ia.clear_busy !== 1'b0) begin
      errors++; $display("FAIL clear_end: got en=%b busy=%b want 0/0", ia.wr_en, ia.clear_busy);
    end
  endtask

  // Queued entries are flushed by clear; a request taken mid-sweep follows it.
  task automatic test_clear_flush();
    ia.wr_allow = 1'b0;
    drive_a(1, 2, 1, 4); tick();
    drive_a(1, 3, 0, 6); tick();
    drive_a(0, 0, 0, 0);
    ia.clear_start = 1'b1; ia.clear_color = 3'd5; ia.wr_allow = 1'b1;
    tick();
    ia.clear_start = 1'b0;
    for (int i = 0; i <= W * H; i++) begin
      int ex, ey, ec;
      if (i < W * H) begin ex = i % W; ey = i / W; ec = 5; end
      else begin ex = 1; ey = 1; ec = 2; end
      if (i == 2) drive_a(1, 1, 1, 2);
      tick();
      drive_a(0, 0, 0, 0);
      checks++;
      if (ia.wr_en !== 1'b1 || ia.wr_x !== coord_t'(ex) || ia.wr_y !== coord_t'(ey)
          || ia.wr_color !== color_t'(ec)) begin
        errors++; $display("FAIL flush_seq[%0d]: got en=%b (%0d,%0d,c%0d) want en=1 (%0d,%0d,c%0d)",
          i, ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ex, ey, ec);
      end
    end
    tick();
    obs_q.delete();
    repeat (4) tick();
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL flushed_written: got %0d extra writes want 0", obs_q.size());
    end
  endtask

  // Range check on the full-size canvas, including both edges.
  task automatic test_drop();
    drive_b(1, 200, 5, 1); tick(); drive_b(0, 0, 0, 0);
    checks++;
    if (ib.dropped !== 1'b1 || ib.wr_en !== 1'b0) begin
      errors++; $display("FAIL drop_200: got drop=%b en=%b want 1/0", ib.dropped, ib.wr_en);
    end
    tick();
    checks++;
    if (ib.dropped !== 1'b0 || ib.wr_en !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: got drop=%b en=%b want 0/0", ib.dropped, ib.wr_en);
    end
    drive_b(1, 159, 119, 7); tick(); drive_b(0, 0, 0, 0);
    checks++;
    if (ib.wr_en !== 1'b1 || ib.wr_x !== 8'd159 || ib.wr_y !== 8'd119 || ib.dropped !== 1'b0) begin
      errors++; $display("FAIL edge_in: got en=%b (%0d,%0d) drop=%b want en=1 (159,119) drop=0",
        ib.wr_en, ib.wr_x, ib.wr_y, ib.dropped);
    end
    drive_b(1, 160, 0, 2); tick();
    checks++;
    if (ib.dropped !== 1'b1 || ib.wr_en !== 1'b0) begin
      errors++; $display("FAIL drop_x160: got drop=%b en=%b want 1/0", ib.dropped, ib.wr_en);
    end
    drive_b(1, 0, 120, 2); tick(); drive_b(0, 0, 0, 0);
    checks++;
    if (ib.dropped !== 1'b1 || ib.wr_en !== 1'b0) begin
      errors++; $display("FAIL drop_y120: got drop=%b en=%b want 1/0", ib.dropped, ib.wr_en);
    end
    tick();
  endtask

  // Random brush traffic and stalls; written stream must equal accepted in-range requests.
  task automatic test_random_brush();
    pix_req_t exp_q[$];
    pix_req_t e;
    int exp_drop = 0;
    bit allow_prev;
    int x, y, stray = 0;
    obs_q.delete(); drop_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      x = $urandom_range(0, 5); y = $urandom_range(0, 2);
      ia.wr_allow = ($urandom_range(0, 9) < 7);
      drive_a($urandom_range(0, 1), x, y, $urandom_range(0, 7));
      #1;
      if (ia.req_valid && ia.req_ready) begin
        if (x < W && y < H) begin
          e.x = coord_t'(x); e.y = coord_t'(y); e.color = ia.req_color;
          exp_q.push_back(e);
        end else exp_drop++;
      end
      allow_prev = ia.wr_allow;
      tick();
      if (ia.wr_en === 1'b1 && !allow_prev) stray++;
    end
    drive_a(0, 0, 0, 0); ia.wr_allow = 1'b1;
    repeat (8) tick();
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rnd_stall: got %0d writes after wr_allow=0 want 0", stray);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd_write[%0d]: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", i,
            obs_q[i].x, obs_q[i].y, obs_q[i].color, exp_q[i].x, exp_q[i].y, exp_q[i].color);
        end
      end
    end
    checks++;
    if (drop_cnt != exp_drop) begin
      errors++; $display("FAIL rnd_drops: got %0d want %0d", drop_cnt, exp_drop);
    end
  endtask

  // Sweep under random stalls with an ignored restart; then reset mid-sweep.
  task automatic test_sweep_stall_reset();
    int col, cyc, dup;
    bit seen[W*H];
    col = $urandom_range(0, 7);
    obs_q.delete();
    ia.clear_start = 1'b1; ia.clear_color = color_t'(col); ia.wr_allow = 1'b1;
    tick();
    ia.clear_start = 1'b0;
    cyc = 0;
    while (ia.clear_busy === 1'b1 && cyc < 300) begin
      ia.wr_allow = $urandom_range(0, 1);
      if (cyc == 3) begin ia.clear_start = 1'b1; ia.clear_color = color_t'(col ^ 7); end
      tick();
      ia.clear_start = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc >= 300) begin
      errors++; $display("FAIL sweep_timeout: clear_busy still %b after %0d cycles", ia.clear_busy, cyc);
    end
    checks++;
    if (obs_q.size() != W * H) begin
      errors++; $display("FAIL sweep_count: got %0d writes want %0d", obs_q.size(), W * H);
    end
    dup = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (int'(obs_q[i].x) < W && int'(obs_q[i].y) < H) begin
        if (seen[obs_q[i].y * W + obs_q[i].x]) dup++;
        seen[obs_q[i].y * W + obs_q[i].x] = 1'b1;
      end
      if (i < W * H) begin
        checks++;
        if (obs_q[i].x !== coord_t'(i % W) || obs_q[i].y !== coord_t'(i / W)
            || obs_q[i].color !== color_t'(col)) begin
          errors++; $display("FAIL sweep_px[%0d]: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
            i, obs_q[i].x, obs_q[i].y, obs_q[i].color, i % W, i / W, col);
        end
      end
    end
    checks++;
    if (dup != 0) begin
      errors++; $display("FAIL sweep_dup: got %0d duplicate coordinates want 0", dup);
    end

    ia.wr_allow = 1'b1;
    ia.clear_start = 1'b1; ia.clear_color = 3'd6;
    tick();
    ia.clear_start = 1'b0;
    drive_a(1, 1, 0, 3); tick(); drive_a(0, 0, 0, 0);
    tick();
    checks++;
    if (ia.clear_busy !== 1'b1 || ia.wr_en !== 1'b1) begin
      errors++; $display("FAIL midsweep: got busy=%b en=%b want 1/1", ia.clear_busy, ia.wr_en);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ia.clear_busy, ia.dropped, ia.req_ready} !== '0) begin
      errors++; $display("FAIL midsweep_reset: got en=%b x=%0d y=%0d c=%0d busy=%b drop=%b rdy=%b want all 0",
        ia.wr_en, ia.wr_x, ia.wr_y, ia.wr_color, ia.clear_busy, ia.dropped, ia.req_ready);
    end
    reset = 1'b0;
    obs_q.delete();
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 0 || ia.clear_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got %0d writes busy=%b want 0/0", obs_q.size(), ia.clear_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clear();
    test_clear_flush();
    test_drop();
    test_random_brush();
    test_sweep_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
